// File: rtl/mux4_rr_arbiter_if.sv
// Bundle between the four producers, the arbiter and the downstream consumer.
// master: arbiter side. slave: producer/consumer side.
interface mux4_rr_arbiter_if #(
   parameter int W = 8
);
   logic [3:0]     req_i;
   logic [4*W-1:0] data_i;
   logic [3:0]     ack_o;
   logic           out_valid;
   logic [W-1:0]   out_data;
   logic           out_ready;
   logic [1:0]     out_sel;

   modport master (
      input  req_i, data_i, out_ready,
      output ack_o, out_valid, out_data, out_sel
   );

   modport slave (
      output req_i, data_i, out_ready,
      input  ack_o, out_valid, out_data, out_sel
   );
endinterface

// File: rtl/mux4_rr_arbiter.sv
// Round-robin controller for a 4:1 mux sharing one valid/ready output channel.
// A grant lasts until BURST_MAX words are accepted or the owner drops its request;
// every grant is preceded by one arbitration cycle in IDLE.
//
// state | meaning
// IDLE  | arbitrate: pick first requester scanning from ptr, output idle
// GRANT | forward data of requester sel, ack each accepted word
module mux4_rr_arbiter #(
   parameter int W         = 8,
   parameter int BURST_MAX = 4
) (
   input  logic              clk,
   input  logic              reset,
   mux4_rr_arbiter_if.master bus
);

   localparam int CW = $clog2(BURST_MAX) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BURST_MAX - 1);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_GRANT = 1'b1;

   logic [0:0]    state_q, state_d;
   logic [1:0]    ptr_q, ptr_d;
   logic [1:0]    sel_q, sel_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic          win_found;
   logic [1:0]    win_idx;
   logic [1:0]    scan_idx;
   logic [W-1:0]  data_sel;
   logic          valid_int;
   logic          xfer;

   // Round-robin search starting at ptr, wrapping 3 -> 0.
   always_comb begin
      win_found = 1'b0;
      win_idx   = ptr_q;
      scan_idx  = ptr_q;
      for (int i = 0; i < 4; i++) begin
         scan_idx = ptr_q + 2'(i);
         if (!win_found && bus.req_i[scan_idx]) begin
            win_found = 1'b1;
            win_idx   = scan_idx;
         end
      end
   end

   // Data mux for the granted requester.
   always_comb begin
      data_sel = '0;
      for (int i = 0; i < 4; i++) begin
         if (sel_q == 2'(i)) begin
            data_sel = bus.data_i[i*W +: W];
         end
      end
   end

   // Output channel; reset forces everything quiet regardless of state.
   always_comb begin
      valid_int     = (state_q == ST_GRANT) && bus.req_i[sel_q] && !reset;
      xfer          = valid_int && bus.out_ready;
      bus.out_valid = valid_int;
      bus.out_data  = valid_int ? data_sel : '0;
      bus.out_sel   = reset ? 2'd0 : sel_q;
      bus.ack_o     = xfer ? (4'b0001 << sel_q) : 4'b0000;
   end

   // Next-state: arbitration in IDLE, burst counting and release in GRANT.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (win_found) begin
               sel_d   = win_idx;
               cnt_d   = '0;
               state_d = ST_GRANT;
            end
         end
         default: begin
            if (!bus.req_i[sel_q]) begin
               ptr_d   = sel_q + 2'd1;
               state_d = ST_IDLE;
            end else if (xfer) begin
               if (cnt_q == CNT_LAST) begin
                  ptr_d   = sel_q + 2'd1;
                  state_d = ST_IDLE;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         ptr_q   <= 2'd0;
         sel_q   <= 2'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Randomized bench for mux4_rr_arbiter with a cycle-level reference model and
// a scoreboard queue drained by an independent monitor.
module tb_mux4_rr_arbiter;
   localparam int W         = 8;
   localparam int BURST_MAX = 4;

   logic clk;
   logic reset;

   mux4_rr_arbiter_if #(.W(W)) bus ();

   mux4_rr_arbiter #(.W(W), .BURST_MAX(BURST_MAX)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      int           cyc;
      logic         v;
      logic [1:0]   sel;
      logic [W-1:0] d;
      logic [3:0]   ack;
   } exp_t;

   exp_t exp_q[$];

   int n_vec  = 0;
   int n_fail = 0;
   bit started = 1'b0;
   int cyc = 0;

   // reference model: owner = -1 means nobody holds the channel
   int m_owner = -1;
   int m_ptr   = 0;
   int m_cnt   = 0;
   int m_sel   = 0;

   logic [3:0]   rq;
   logic [W-1:0] rd [4];
   logic         rdy;
   logic [3:0]   last_ack;

   function automatic bit chance(input int pct);
      return ($urandom_range(99) < pct);
   endfunction

   task automatic drive_cycle(input bit rst_v, input int raise_pct, input int drop_pct,
                              input int ready_pct, input int force_req);
      exp_t e;
      @(posedge clk);
      #1;
      cyc++;
      for (int n = 0; n < 4; n++) begin
         if (force_req != 0) begin
            if (last_ack[n] || !rq[n]) rd[n] = W'($urandom);
            rq[n] = 1'b1;
         end else if (last_ack[n]) begin
            rd[n] = W'($urandom);
            rq[n] = chance(raise_pct);
         end else if (rq[n]) begin
            if (chance(drop_pct)) rq[n] = 1'b0;
         end else if (chance(raise_pct)) begin
            rq[n] = 1'b1;
            rd[n] = W'($urandom);
         end
      end
      rdy   = chance(ready_pct);
      reset = rst_v;
      bus.req_i     = rq;
      bus.data_i    = {rd[3], rd[2], rd[1], rd[0]};
      bus.out_ready = rdy;

      e.cyc = cyc;
      e.v   = 1'b0;
      e.d   = '0;
      e.ack = 4'b0000;
      if (rst_v) begin
         e.sel   = 2'd0;
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
         m_sel   = 0;
      end else if (m_owner < 0) begin
         e.sel = 2'(m_sel);
         for (int k = 0; k < 4; k++) begin
            if (m_owner < 0 && rq[(m_ptr + k) % 4]) m_owner = (m_ptr + k) % 4;
         end
         if (m_owner >= 0) begin
            m_sel = m_owner;
            m_cnt = 0;
         end
      end else begin
         e.sel = 2'(m_owner);
         e.v   = rq[m_owner];
         if (!e.v) begin
            m_ptr   = (m_owner + 1) % 4;
            m_owner = -1;
         end else begin
            e.d = rd[m_owner];
            if (rdy) begin
               e.ack = 4'(1 << m_owner);
               m_cnt++;
               if (m_cnt == BURST_MAX) begin
                  m_ptr   = (m_owner + 1) % 4;
                  m_owner = -1;
               end
            end
         end
      end
      last_ack = e.ack;
      exp_q.push_back(e);
      started = 1'b1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req, input int c);
      n_vec++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s cycle %0d: got %0h expected %0h", name, c, act, req);
      end
   endtask

   // monitor: pops one expected record per cycle, samples mid-cycle
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (started) begin
            if (exp_q.size() == 0) begin
               n_vec++;
               n_fail++;
               $display("FAIL scoreboard_underflow: got empty queue expected a record");
            end else begin
               e = exp_q.pop_front();
               check("out_valid", 32'(bus.out_valid), 32'(e.v), e.cyc);
               check("ack_o", 32'(bus.ack_o), 32'(e.ack), e.cyc);
               check("out_data", 32'(bus.out_data), 32'(e.d), e.cyc);
               check("out_sel", 32'(bus.out_sel), 32'(e.sel), e.cyc);
            end
         end
      end
   end

   initial begin
      reset         = 1'b1;
      rq            = 4'h0;
      rdy           = 1'b1;
      last_ack      = 4'h0;
      for (int n = 0; n < 4; n++) rd[n] = '0;
      bus.req_i     = 4'h0;
      bus.data_i    = '0;
      bus.out_ready = 1'b1;

      // reset with all requesting, then everybody held requesting with ready high
      for (int i = 0; i < 3; i++) drive_cycle(1'b1, 100, 0, 100, 1);
      for (int i = 0; i < 30; i++) drive_cycle(1'b0, 100, 0, 100, 1);
      // heavy backpressure with sparse requests
      for (int i = 0; i < 200; i++) drive_cycle(1'b0, 20, 3, 25, 0);
      // general random traffic with occasional reset pulses
      for (int i = 0; i < 3000; i++) drive_cycle(chance(1), 40, 5, 70, 0);
      // saturated traffic
      for (int i = 0; i < 300; i++) drive_cycle(1'b0, 100, 0, 90, 0);

      @(negedge clk);
      #1;
      n_vec++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
